// File: rtl/bip_pkg.sv
// ============================================================================
// Module      : bip_pkg
// Description : Shared encodings and default widths for the BIP control unit
//               and accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bip_pkg;

    localparam int BIP_NB_DATA          = 16;
    localparam int BIP_NB_OPERAND       = 11;
    localparam int BIP_NB_DATA_ADDR     = 10;
    localparam int BIP_NB_DECODER_SEL_A = 2;

    typedef enum logic [1:0] {
        SEL_A_MEM = 2'd0,
        SEL_A_IMM = 2'd1,
        SEL_A_ALU = 2'd2,
        SEL_A_ACC = 2'd3
    } sel_a_e;

    typedef enum logic {
        SEL_B_MEM = 1'b0,
        SEL_B_IMM = 1'b1
    } sel_b_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

endpackage : bip_pkg

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : BIP data memory, combinational read / synchronous write,
//               no reset (contents survive datapath reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory #(
    parameter int NB_DATA      = 16,
    parameter int NB_DATA_ADDR = 10
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [NB_DATA_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0]      i_wdata,
    output logic [NB_DATA-1:0]      o_rdata
);

    localparam int DEPTH = 1 << NB_DATA_ADDR;

    logic [NB_DATA-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    // Read sees pre-edge contents, so a same-address read/write returns old data.
    assign o_rdata = mem_q[i_addr];

endmodule : data_memory

`default_nettype wire

// File: rtl/bip_datapath.sv
// ============================================================================
// Module      : bip_datapath
// Description : BIP accumulator datapath: sign extension, add/sub ALU,
//               accumulator and data memory. Optional registered zero/neg
//               flags are enabled with `define BIP_DATAPATH_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bip_datapath
    import bip_pkg::*;
#(
    parameter int NB_DATA          = BIP_NB_DATA,
    parameter int NB_OPERAND       = BIP_NB_OPERAND,
    parameter int NB_DATA_ADDR     = BIP_NB_DATA_ADDR,
    parameter int NB_DECODER_SEL_A = BIP_NB_DECODER_SEL_A
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NB_DECODER_SEL_A-1:0] i_selA,
    input  logic                        i_selB,
    input  logic                        i_wrAcc,
    input  logic                        i_op,
    input  logic                        i_wrRam,
    input  logic                        i_rdRam,
    input  logic [NB_OPERAND-1:0]       i_operand,
    output logic [NB_DATA-1:0]          o_acc,
    output logic                        o_zero,
    output logic                        o_neg
);

    logic [NB_DATA-1:0]      acc_q;
    logic [NB_DATA-1:0]      acc_d;
    logic [NB_DATA-1:0]      w_acc_mux;
    logic [NB_DATA-1:0]      w_imm;
    logic [NB_DATA-1:0]      w_mem_rdata;
    logic [NB_DATA-1:0]      w_mem_data;
    logic [NB_DATA-1:0]      w_alu_b;
    logic [NB_DATA-1:0]      w_alu;
    logic [NB_DATA_ADDR-1:0] w_addr;
    logic                    w_mem_we;

    assign w_imm  = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
    assign w_addr = i_operand[NB_DATA_ADDR-1:0];

    // A store coinciding with reset is dropped; the memory itself has no reset.
    assign w_mem_we = i_wrRam & i_rst;

    data_memory #(
        .NB_DATA      (NB_DATA),
        .NB_DATA_ADDR (NB_DATA_ADDR)
    ) u_data_memory (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_addr  (w_addr),
        .i_wdata (acc_q),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_mem_data = '0;
        w_alu_b    = '0;
        w_alu      = '0;
        w_acc_mux  = acc_q;
        acc_d      = acc_q;

        if (i_rdRam) begin
            w_mem_data = w_mem_rdata;
        end

        w_alu_b = (i_selB == SEL_B_IMM) ? w_imm : w_mem_data;
        w_alu   = (i_op == OP_SUB) ? (acc_q - w_alu_b) : (acc_q + w_alu_b);

        case (i_selA)
            SEL_A_MEM: w_acc_mux = w_mem_data;
            SEL_A_IMM: w_acc_mux = w_imm;
            SEL_A_ALU: w_acc_mux = w_alu;
            default:   w_acc_mux = acc_q;
        endcase

        if (i_wrAcc) begin
            acc_d = w_acc_mux;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

`ifdef BIP_DATAPATH_FLAGS_EN
    logic zero_q;
    logic zero_d;
    logic neg_q;
    logic neg_d;

    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (i_wrAcc) begin
            zero_d = (w_acc_mux == '0);
            neg_d  = w_acc_mux[NB_DATA-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign o_zero = zero_q;
    assign o_neg  = neg_q;
`else
    assign o_zero = 1'b0;
    assign o_neg  = 1'b0;
`endif

endmodule : bip_datapath

`default_nettype wire

// File: tb/tb_bip_datapath.sv
// ============================================================================
// Module      : tb_bip_datapath
// Description : Directed, table-driven self-checking bench for bip_datapath,
//               plus hand sequences for halt, reset and discarded store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bip_datapath;

    logic        i_clk;
    logic        i_rst;
    logic [1:0]  i_selA;
    logic        i_selB;
    logic        i_wrAcc;
    logic        i_op;
    logic        i_wrRam;
    logic        i_rdRam;
    logic [10:0] i_operand;
    logic [15:0] o_acc;
    logic        o_zero;
    logic        o_neg;

    bip_datapath dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_selA    (i_selA),
        .i_selB    (i_selB),
        .i_wrAcc   (i_wrAcc),
        .i_op      (i_op),
        .i_wrRam   (i_wrRam),
        .i_rdRam   (i_rdRam),
        .i_operand (i_operand),
        .o_acc     (o_acc),
        .o_zero    (o_zero),
        .o_neg     (o_neg)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        wr_acc;
        logic        op;
        logic        wr_ram;
        logic        rd_ram;
        logic [10:0] operand;
        logic [15:0] exp_acc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_z   = 1'b0;
    logic exp_n   = 1'b0;

    function automatic void add(input logic [1:0] sa, input logic sb, input logic wa,
                                input logic op, input logic wr, input logic rd,
                                input logic [10:0] operand, input logic [15:0] exp_acc);
        vec_t v;
        v.sel_a = sa; v.sel_b = sb; v.wr_acc = wa; v.op = op;
        v.wr_ram = wr; v.rd_ram = rd; v.operand = operand; v.exp_acc = exp_acc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name);
`ifdef BIP_DATAPATH_FLAGS_EN
        check({name, " zero"}, {15'd0, o_zero}, {15'd0, exp_z});
        check({name, " neg"},  {15'd0, o_neg},  {15'd0, exp_n});
`else
        check({name, " zero"}, {15'd0, o_zero}, 16'd0);
        check({name, " neg"},  {15'd0, o_neg},  16'd0);
`endif
    endtask

    task automatic drive(input logic [1:0] sa, input logic sb, input logic wa,
                         input logic op, input logic wr, input logic rd,
                         input logic [10:0] operand);
        i_selA = sa; i_selB = sb; i_wrAcc = wa; i_op = op;
        i_wrRam = wr; i_rdRam = rd; i_operand = operand;
    endtask

    // Apply one instruction, clock it, and compare against the expected accumulator.
    task automatic step(input string name, input logic [1:0] sa, input logic sb,
                        input logic wa, input logic op, input logic wr, input logic rd,
                        input logic [10:0] operand, input logic [15:0] exp_acc);
        drive(sa, sb, wa, op, wr, rd, operand);
        @(posedge i_clk);
        #1;
        if (wa) begin
            exp_z = (exp_acc == 16'd0);
            exp_n = exp_acc[15];
        end
        check(name, o_acc, exp_acc);
        check_flags(name);
    endtask

    initial begin
        i_rst = 1'b0;
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);

        //   selA selB wrAcc op  wrRam rdRam operand   expected acc
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5,     16'h0005); // LDI 5
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h3FF,   16'h03FF); // largest positive imm
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h400,   16'hFC00); // most negative imm
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF,   16'hFFFF); // -1
        add(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1,     16'h0000); // ADDI 1 wraps
        add(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1,     16'hFFFF); // SUBI 1 wraps
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd3,     16'h0003); // LDI 3
        add(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd10,    16'h0003); // STO 10
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0,     16'h0000); // LDI 0
        add(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd10,    16'h0003); // LD 10
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h01F,   16'h001F); // LDI 31
        add(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1034,  16'h001F); // STO 1034 -> addr 10
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0,     16'h0000); // LDI 0
        add(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd10,    16'h001F); // LD 10 sees alias store
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd7,     16'h0007); // LDI 7
        add(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2,     16'h0009); // STO 2 + ADDI 2
        add(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd2,     16'h0007); // LD 2 = old acc
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd100,   16'h0064); // LDI 100
        add(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd2,     16'h0007); // LD 2 + STO 2: old data
        add(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd2,     16'h0064); // LD 2: new data
        add(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd2,     16'h0000); // SUB mem[2]
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5,     16'h0005); // LDI 5
        add(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd10,    16'h0024); // ADD mem[10]
        add(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd10,    16'h0000); // load with rdRam=0
        add(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5,     16'h0005); // LDI 5
        add(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd10,    16'h0005); // ADD with rdRam=0 adds 0
        add(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h400,   16'h0405); // SUBI -1024
        add(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd10,    16'h0405); // selA hold
        add(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd9,     16'h0405); // wrAcc=0 holds
        add(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd1034,  16'h001F); // LD 1034 -> addr 10

        repeat (2) @(posedge i_clk);
        #1;
        check("reset acc", o_acc, 16'h0000);
        check_flags("reset");
        i_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].sel_a, vecs[i].sel_b, vecs[i].wr_acc,
                 vecs[i].op, vecs[i].wr_ram, vecs[i].rd_ram, vecs[i].operand, vecs[i].exp_acc);
        end

        // Halt with random operand: nothing may change.
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hlt%0d", i), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 11'($urandom_range(0, 2047)), 16'h001F);
        end
        step("hlt mem2", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd2, 16'h0064);
        step("hlt mem10", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd10, 16'h001F);

        // Mid-cycle reset clears acc at once and discards the pending STO.
        step("ldi 0x55", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h055, 16'h0055);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd10);
        #3;
        i_rst = 1'b0;
        #1;
        exp_z = 1'b0;
        exp_n = 1'b0;
        check("async reset acc", o_acc, 16'h0000);
        check_flags("async reset");
        @(posedge i_clk);
        #1;
        check("reset held acc", o_acc, 16'h0000);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        i_rst = 1'b1;
        step("store discarded", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd10, 16'h001F);
        step("ldi after reset", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5, 16'h0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bip_datapath

`default_nettype wire
